// File: rtl/fft64_pipe_ctrl_if.sv
// Purpose : control bundle between the FFT64 pipeline controller and its surroundings.
// Latency : n/a (wires only); upstream drives in_sof/in_valid, controller drives the rest.
// Backpressure: none; ed is the single pipeline-wide enable, there is no ready path.
// Ports   : in_sof, in_valid (upstream); ed, start1, start_rot, start2 (to pipeline stages);
//           out_sof, out_valid, busy, err_sof, frame_cnt[7:0] (status / downstream).
interface fft64_pipe_ctrl_if;
    logic       in_sof;
    logic       in_valid;
    logic       ed;
    logic       start1;
    logic       start_rot;
    logic       start2;
    logic       out_sof;
    logic       out_valid;
    logic       busy;
    logic       err_sof;
    logic [7:0] frame_cnt;

    // Upstream / environment side
    modport master (
        output in_sof, in_valid,
        input  ed, start1, start_rot, start2, out_sof, out_valid, busy, err_sof, frame_cnt
    );

    // Controller side
    modport slave (
        input  in_sof, in_valid,
        output ed, start1, start_rot, start2, out_sof, out_valid, busy, err_sof, frame_cnt
    );
endinterface

// File: rtl/fft64_pipe_ctrl.sv
// Purpose : sequences START pulses through stage 1 -> rotator -> stage 2 of a 64-point FFT
//           and frames the output; tracks frames in flight and flushes the pipe when input stops.
// Latency : START1 -> OUT_SOF = L1+LR+L2 ED cycles; OUT_VALID for the 64 ED cycles after OUT_SOF.
// Backpressure: none; ED follows IN_VALID while a frame is open or idle, forced high while draining.
// Ports   : CLK (rising edge), RST (sync, active-high), bus (fft64_pipe_ctrl_if.slave).
module fft64_pipe_ctrl #(
    parameter int L1 = 68,  // stage-1 START -> first output strobe, ED cycles
    parameter int LR = 3,   // rotator START -> RDY, ED cycles
    parameter int L2 = 68   // stage-2 START -> first output strobe, ED cycles
) (
    input  logic              CLK,
    input  logic              RST,
    fft64_pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

    state_t        state, state_nxt;
    logic [5:0]    in_cnt, in_cnt_nxt;
    logic [7:0]    inflight, inflight_nxt;
    logic [7:0]    frame_cnt;
    logic [L1-1:0] rot_dly;
    logic [LR-1:0] s2_dly;
    logic [L2-1:0] sof_dly;
    logic          out_open;
    logic [5:0]    out_cnt;
    logic          err_sof;

    logic          ed;
    logic          start1;
    logic          out_sof;
    logic          misplaced;
    logic          win_end;

    // Draining frames self-clock the pipe so the tail comes out without upstream help.
    assign ed        = ((state == WAIT) && !RST) ? 1'b1 : bus.in_valid;
    assign start1    = bus.in_sof & ed & ~RST;
    assign out_sof   = sof_dly[L2-1];
    assign misplaced = start1 && (state == FILL) && (in_cnt != 6'd63);

    // A window retires its frame on the 64th sample, or early when a newer OUT_SOF
    // truncates it; otherwise an aborted frame would stay in flight forever.
    assign win_end   = ed && out_open && ((out_cnt == 6'd63) || out_sof);

    always_comb begin
        state_nxt    = state;
        in_cnt_nxt   = in_cnt;
        inflight_nxt = inflight;

        if (start1 && !win_end)
            inflight_nxt = inflight + 8'd1;
        else if (win_end && !start1)
            inflight_nxt = inflight - 8'd1;

        case (state)
            IDLE: ;
            FILL: begin
                if (ed) begin
                    if (in_cnt == 6'd63)
                        state_nxt = WAIT;
                    else
                        in_cnt_nxt = in_cnt + 6'd1;
                end
            end
            WAIT: begin
                if (inflight_nxt == 8'd0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A new frame always wins, including on the last sample of the previous one.
        if (start1) begin
            state_nxt  = FILL;
            in_cnt_nxt = 6'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            in_cnt    <= '0;
            inflight  <= '0;
            frame_cnt <= '0;
            rot_dly   <= '0;
            s2_dly    <= '0;
            sof_dly   <= '0;
            out_open  <= 1'b0;
            out_cnt   <= '0;
            err_sof   <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_cnt   <= in_cnt_nxt;
            inflight <= inflight_nxt;
            err_sof  <= misplaced;

            // Delay lines advance only on ED so stalls stretch latency in clock cycles
            // but not in pipeline cycles; each bit is an independent in-flight start.
            if (ed) begin
                rot_dly <= (rot_dly << 1) | L1'(start1);
                s2_dly  <= (s2_dly  << 1) | LR'(rot_dly[L1-1]);
                sof_dly <= (sof_dly << 1) | L2'(s2_dly[LR-1]);

                if (out_sof) begin
                    out_open <= 1'b1;
                    out_cnt  <= '0;
                end else if (out_open) begin
                    if (out_cnt == 6'd63)
                        out_open <= 1'b0;
                    out_cnt <= out_cnt + 6'd1;
                end
            end

            if (win_end)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign bus.ed        = ed;
    assign bus.start1    = start1;
    assign bus.start_rot = rot_dly[L1-1];
    assign bus.start2    = s2_dly[LR-1];
    assign bus.out_sof   = out_sof;
    assign bus.out_valid = out_open & ed;
    assign bus.busy      = (inflight != 8'd0);
    assign bus.err_sof   = err_sof;
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_fft64_pipe_ctrl.sv
// Purpose : self-checking bench for fft64_pipe_ctrl; expected START/OUT_SOF times and output
//           windows are queued when a frame is driven and matched as the DUT produces them.
// Latency : n/a.  Backpressure: n/a.
module tb_fft64_pipe_ctrl;
    localparam int L1  = 68;
    localparam int LR  = 3;
    localparam int L2  = 68;
    localparam int LAT = L1 + LR + L2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft64_pipe_ctrl_if bus();

    fft64_pipe_ctrl #(.L1(L1), .LR(LR), .L2(L2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ED-cycle and clock-cycle time bases; both hold the index of the current cycle
    // between the rising edge and the next falling edge.
    int edc   = 0;
    int cycnt = 0;
    int qrot[$], qs2[$], qsof[$], starts[$];
    int ov_bad, ov_n, run, max_run, ov_last, err_n, err_cyc, unexp;
    int rot_cyc, osof_cyc, idle_cyc, sof_cyc;
    bit busy_q = 1'b0;
    int exp_fc = 0;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ed) begin
                bit expv;
                if (bus.start_rot) begin
                    rot_cyc = cycnt;
                    if (qrot.size() != 0) chk("start_rot_time", edc, qrot.pop_front());
                    else unexp++;
                end
                if (bus.start2) begin
                    if (qs2.size() != 0) chk("start2_time", edc, qs2.pop_front());
                    else unexp++;
                end
                if (bus.out_sof) begin
                    osof_cyc = cycnt;
                    if (qsof.size() != 0) chk("out_sof_time", edc, qsof.pop_front());
                    else unexp++;
                end
                expv = 1'b0;
                foreach (starts[i])
                    if (edc >= starts[i] + LAT + 1 && edc <= starts[i] + LAT + 64) expv = 1'b1;
                if (bus.out_valid != expv) ov_bad++;
                edc++;
            end else if (bus.out_valid) begin
                ov_bad++;
            end
            if (bus.out_valid) begin
                ov_n++;
                run++;
                ov_last = cycnt;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.err_sof) begin
                err_n++;
                err_cyc = cycnt;
            end
            if (busy_q && !bus.busy) idle_cyc = cycnt;
            busy_q = bus.busy;
        end
        cycnt++;
    end

    // One clock cycle of upstream stimulus; a frame start is scored when driven.
    task automatic cyc(input bit sof, input bit v);
        @(posedge clk);
        #1;
        bus.in_sof   = sof;
        bus.in_valid = v;
        if (sof && v) begin
            qrot.push_back(edc + L1);
            qs2.push_back(edc + L1 + LR);
            qsof.push_back(edc + LAT);
            starts.push_back(edc);
            sof_cyc = cycnt;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        do begin
            cyc(1'b0, 1'b0);
            @(negedge clk);
            #1;
            n++;
        end while ((bus.busy || qsof.size() != 0) && n < budget);
        chk({tag, ".drain_in_budget"}, int'(n < budget), 1);
    endtask

    task automatic clr();
        ov_bad = 0; ov_n = 0; run = 0; max_run = 0; ov_last = -1;
        err_n = 0; err_cyc = -1; unexp = 0; idle_cyc = -1;
        starts.delete();
    endtask

    task automatic end_test(input string tag, input int frames, input int ovn, input int err);
        exp_fc += frames;
        chk({tag, ".frame_cnt"}, bus.frame_cnt, exp_fc % 256);
        chk({tag, ".busy"},      bus.busy, 0);
        chk({tag, ".ov_count"},  ov_n, ovn);
        chk({tag, ".ov_run"},    max_run, ovn);
        chk({tag, ".ov_bad"},    ov_bad, 0);
        chk({tag, ".unexpected"}, unexp, 0);
        chk({tag, ".pending"},   qrot.size() + qs2.size() + qsof.size(), 0);
        chk({tag, ".err_sof"},   err_n, err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, cnt;

        // Reset state: outputs quiet even with SOF/VALID asserted, ED follows IN_VALID.
        rst = 1'b1;
        bus.in_sof = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.start1",    bus.start1, 0);
        chk("rst.ed_follow", bus.ed, 1);
        chk("rst.busy",      bus.busy, 0);
        chk("rst.frame_cnt", bus.frame_cnt, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.err_sof",   bus.err_sof, 0);
        chk("rst.starts",    bus.start_rot + bus.start2 + bus.out_sof, 0);
        bus.in_valid = 1'b0;
        #1;
        chk("rst.ed_low", bus.ed, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_sof = 1'b0;

        // Single frame
        clr();
        cyc(1, 1);
        repeat (64) cyc(0, 1);
        drain("single", 400);
        end_test("single", 1, 64, 0);

        // Three back-to-back frames, each SOF on the previous frame's last sample
        clr();
        cyc(1, 1);
        for (int f = 0; f < 3; f++) begin
            repeat (63) cyc(0, 1);
            cyc(f < 2, 1);
        end
        drain("b2b", 600);
        end_test("b2b", 3, 192, 0);

        // Ten-cycle input stall mid-frame
        clr();
        cyc(1, 1);
        s0 = sof_cyc;
        repeat (30) cyc(0, 1);
        cnt = 0;
        repeat (10) begin
            cyc(0, 0);
            @(negedge clk);
            if (bus.ed) cnt++;
        end
        chk("stall.ed_low", cnt, 0);
        repeat (34) cyc(0, 1);
        drain("stall", 400);
        chk("stall.rot_clk_latency", rot_cyc - s0, L1 + 10);
        end_test("stall", 1, 64, 0);

        // Misplaced SOF at input counter 20: both frames come out, the first truncated
        clr();
        cyc(1, 1);
        repeat (20) cyc(0, 1);
        cyc(1, 1);
        s1 = sof_cyc;
        repeat (64) cyc(0, 1);
        drain("mis", 600);
        chk("mis.err_cycle", err_cyc, s1 + 1);
        end_test("mis", 2, 85, 1);

        // Flush with IN_VALID held low after the frame
        clr();
        cyc(1, 1);
        s0 = sof_cyc;
        repeat (64) cyc(0, 1);
        cnt = 0;
        repeat (100) begin
            cyc(0, 0);
            @(negedge clk);
            if (!bus.ed) cnt++;
        end
        chk("flush.wait_ed_high", cnt, 0);
        drain("flush", 400);
        chk("flush.sof_latency", osof_cyc - s0, LAT);
        chk("flush.idle_after_last_ov", idle_cyc, ov_last + 1);
        chk("flush.ed_idle", bus.ed, 0);
        end_test("flush", 1, 64, 0);

        // Reset at ED-cycle 100 of a frame: nothing from it may emerge afterwards
        clr();
        cyc(1, 1);
        repeat (64) cyc(0, 1);
        repeat (35) cyc(0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_sof = 1'b0;
        bus.in_valid = 1'b0;
        qrot.delete();
        qs2.delete();
        qsof.delete();
        starts.delete();
        exp_fc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_q = 1'b0;
        clr();
        repeat (300) cyc(0, 0);
        @(negedge clk);
        #1;
        chk("rstmid.busy",       bus.busy, 0);
        chk("rstmid.frame_cnt",  bus.frame_cnt, 0);
        chk("rstmid.unexpected", unexp, 0);
        chk("rstmid.ov_count",   ov_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft64_pipe_ctrl.md
FFT64_PIPE_CTRL -- requirements
Module: fft64_pipe_ctrl

Interface
REQ-001 SHALL have parameter L1, default 68: ED-qualified cycles from stage-1 START to stage-1 first-output strobe.
REQ-002 SHALL have parameter LR, default 3: ED-qualified cycles from rotator START to rotator RDY.
REQ-003 SHALL have parameter L2, default 68: ED-qualified cycles from stage-2 START to stage-2 first-output strobe.
REQ-004 SHALL have ports: CLK in 1, clock, all logic on rising edge.
REQ-005 RST in 1, reset, synchronous, active-high.
REQ-006 IN_SOF in 1, frame announce; first sample of the frame follows on the next ED cycle.
REQ-007 IN_VALID in 1, upstream sample present this cycle.
REQ-008 ED out 1, global pipeline enable driven to stage 1, rotator and stage 2.
REQ-009 START1 out 1, START to stage 1.
REQ-010 START_ROT out 1, START to rotator.
REQ-011 START2 out 1, START to stage 2.
REQ-012 OUT_SOF out 1, output-frame announce.
REQ-013 OUT_VALID out 1, output sample valid.
REQ-014 BUSY out 1, at least one frame in flight.
REQ-015 ERR_SOF out 1, one-cycle pulse on a misplaced IN_SOF.
REQ-016 FRAME_CNT out 8, count of completed output frames, wraps 255->0.

Function
REQ-017 SHALL implement states IDLE, FILL and WAIT.
- IDLE: no frames in flight.
- FILL: 64-sample input frame open.
- WAIT: no input frame open, frames in flight.
REQ-018 ED SHALL be combinational: IN_VALID in IDLE and FILL; constant 1 in WAIT (self-flush).
REQ-019 START1 SHALL equal IN_SOF & ED; any state -> FILL on START1, input sample counter cleared to 0.
REQ-020 In FILL the 6-bit input counter SHALL increment on each ED cycle after START1; on the 64th sample (counter 63 & ED) -> WAIT, unless START1 occurs in the same cycle (stays FILL, counter 0).
REQ-021 START1 in FILL with counter != 63 SHALL pulse ERR_SOF next cycle; the aborted frame stays counted in flight, the new frame is accepted.
REQ-022 START_ROT SHALL be START1 delayed by exactly L1 ED cycles.
- Implementation: 1-bit ED-gated shift line.
- No state change on non-ED cycles.
- Multiple in-flight starts preserved.
REQ-023 START2 SHALL be START_ROT delayed LR ED cycles; OUT_SOF SHALL be START2 delayed L2 ED cycles; all three registered.
REQ-024 Total START1->OUT_SOF latency SHALL be L1+LR+L2 ED cycles (139 at defaults).
REQ-025 OUT_VALID SHALL be high for the 64 ED cycles following OUT_SOF, gated by ED; an OUT_SOF during an open output window restarts the 64-count.
REQ-026 In-flight counter (8-bit): +1 on START1, -1 when an output window completes its 64th sample; simultaneous events leave it unchanged.
REQ-027 BUSY SHALL be in-flight != 0.
REQ-028 FRAME_CNT SHALL increment when an output window completes its 64th sample.
REQ-029 WAIT -> IDLE when in-flight reaches 0 with no START1 that cycle.
REQ-030 IN_VALID without a frame open (IDLE/WAIT) SHALL be ignored by the control logic.

Reset
REQ-031 While RST is high, all registers SHALL clear on the next edge.
- State IDLE.
- All delay lines and counters zero.
- Outputs START1/START_ROT/START2/OUT_SOF/OUT_VALID/ERR_SOF/BUSY = 0, FRAME_CNT = 0.
- ED follows IN_VALID.
REQ-032 RST mid-frame SHALL discard all in-flight starts; no START_ROT, START2 or OUT_SOF SHALL appear afterwards for pre-reset frames.

Verification
REQ-033 Single frame: IN_SOF+IN_VALID at t0, 64 valid cycles, then idle.
- START_ROT at ED-cycle 68.
- START2 at ED-cycle 71.
- OUT_SOF at ED-cycle 139.
- OUT_VALID for 64 cycles.
- FRAME_CNT = 1, BUSY low afterwards.
REQ-034 Back-to-back: 3 frames, IN_SOF every 64 cycles.
- START_ROT pulses 64 apart.
- 192 contiguous OUT_VALID cycles.
- FRAME_CNT = 3, ERR_SOF never high.
REQ-035 Stall: IN_VALID low for 10 cycles mid-frame.
- ED low for those cycles, START_ROT delayed by exactly 10 cycles.
- No ERR_SOF.
REQ-036 Misplaced SOF: IN_SOF at input counter 20.
- ERR_SOF pulses once.
- Two OUT_SOF pulses eventually appear.
- FRAME_CNT increments by 2.
REQ-037 Reset at ED-cycle 100 of a single frame: no OUT_SOF thereafter, BUSY = 0, FRAME_CNT = 0.
REQ-038 Flush: frame, then IN_VALID held low.
- WAIT drives ED = 1.
- OUT_SOF arrives 139 cycles after START1.
- IDLE reached after the 64th OUT_VALID.
